// File: rtl/fetch_if.sv
// fetch_if: handshake and PC bus between the control unit and the fetch sequencer.
interface fetch_if;
  logic        stall;
  logic        advance;
  logic [1:0]  npc_sel;
  logic [15:0] br_off;
  logic [25:0] j_target;
  logic [31:0] jr_addr;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        imemsrc;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic        addr_err;
  modport master (
    output stall, advance, npc_sel, br_off, j_target, jr_addr, exc_req,
    input  pc, pc4, imemsrc, imem_addr, inst_valid, addr_err
  );
  modport slave (
    input  stall, advance, npc_sel, br_off, j_target, jr_addr, exc_req,
    output pc, pc4, imemsrc, imem_addr, inst_valid, addr_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: two-state instruction-fetch sequencer owning the PC and next-PC selection.
// Define FETCH_ALIGN_TRAP_EN to trap misaligned redirects to EXC_VEC with an addr_err pulse.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0040_0004
) (
  input logic    clk,
  input logic    rst,
  fetch_if.slave bus
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, seq, sel, tgt;
  logic        err, err_q, err_d, accept;
  always_comb begin
    seq = pc_q + 32'd4;
    sel = bus.npc_sel == 2'd0 ? seq :
          bus.npc_sel == 2'd1 ? seq + {{14{bus.br_off[15]}}, bus.br_off, 2'b00} :
          bus.npc_sel == 2'd2 ? {seq[31:28], bus.j_target, 2'b00} : bus.jr_addr;
`ifdef FETCH_ALIGN_TRAP_EN
    err = !bus.exc_req && (sel[1:0] != 2'b00);
    tgt = (bus.exc_req || err) ? EXC_VEC : sel;
`else
    err = 1'b0;
    tgt = bus.exc_req ? EXC_VEC : (sel & ~32'd3);
`endif
    accept  = state_q == HOLD && bus.advance && !bus.stall;
    state_d = accept ? FETCH : (state_q == FETCH && !bus.stall) ? HOLD : state_q;
    pc_d    = accept ? tgt : pc_q;
    err_d   = accept && err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end
  assign bus.pc         = pc_q;
  assign bus.pc4        = seq;
  assign bus.imem_addr  = (pc_q - RESET_PC) >> 2;
  assign bus.imemsrc    = state_q == FETCH && !bus.stall;
  assign bus.inst_valid = state_q == HOLD;
  assign bus.addr_err   = err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plus random stimulus; a queue scoreboard checks every cycle the sequencer presents output.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC  = 32'h0040_0004;
  typedef struct packed {
    logic [31:0] pc, pc4, ia;
    logic        src, vld, err;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   live = 0;
  bit   m_known = 0;
  bit   m_hold = 0;
  bit   m_err = 0;
  logic [31:0] m_pc = RESET_PC;
  obs_t q[$];
  fetch_if fi();
  fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (.clk(clk), .rst(rst), .bus(fi));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] s,
      input logic [15:0] br, input logic [25:0] j, input logic [31:0] jr, output bit bad);
    logic [31:0] seq, n;
    int off;
    int unsigned ji;
    seq = pc + 32'd4;
    off = $signed(br);
    ji  = j;
    n = s == 2'd0 ? seq : s == 2'd1 ? seq + 32'(off * 4) :
        s == 2'd2 ? (seq & 32'hF000_0000) + 32'(ji * 4) : jr;
    bad = 0;
`ifdef FETCH_ALIGN_TRAP_EN
    if (n % 4 != 0) begin
      bad = 1;
      n = EXC_VEC;
    end
`else
    n = n - (n % 4);
`endif
    return n;
  endfunction
  task automatic cyc(input bit r, input bit st, input bit adv, input bit exc, input logic [1:0] s,
      input logic [15:0] br, input logic [25:0] j, input logic [31:0] jr);
    obs_t e;
    bit bad;
    logic [31:0] n;
    @(negedge clk);
    rst = r; fi.stall = st; fi.advance = adv; fi.exc_req = exc;
    fi.npc_sel = s; fi.br_off = br; fi.j_target = j; fi.jr_addr = jr;
    live = m_known;
    e = '{pc: m_pc, pc4: m_pc + 32'd4, ia: (m_pc - RESET_PC) / 4, src: !m_hold && !st, vld: m_hold, err: m_err};
    if (live && (e.src || e.vld || e.err)) q.push_back(e);
    m_err = 0;
    if (r) begin
      m_pc = RESET_PC; m_hold = 0; m_known = 1;
    end else if (m_hold && adv && !st) begin
      n = ref_npc(m_pc, s, br, j, jr, bad);
      m_pc = exc ? EXC_VEC : n;
      m_err = !exc && bad;
      m_hold = 0;
    end else if (!m_hold && !st) m_hold = 1;
  endtask
  task automatic insn(input logic [1:0] s, input logic [15:0] br, input logic [25:0] j,
      input logic [31:0] jr, input bit exc);
    repeat (2) cyc(0, 0, 1, exc, s, br, j, jr);
  endtask
  always @(negedge clk) begin
    obs_t a, e;
    #2;
    a = '{pc: fi.pc, pc4: fi.pc4, ia: fi.imem_addr, src: fi.imemsrc, vld: fi.inst_valid, err: fi.addr_err};
    if (live && (a.src === 1'b1 || a.vld === 1'b1 || a.err === 1'b1)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious t=%0t got pc=%h pc4=%h ia=%h src=%b vld=%b err=%b, expected no output",
                 $time, a.pc, a.pc4, a.ia, a.src, a.vld, a.err);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL txn t=%0t got pc=%h pc4=%h ia=%h src=%b vld=%b err=%b, expected pc=%h pc4=%h ia=%h src=%b vld=%b err=%b",
                   $time, a.pc, a.pc4, a.ia, a.src, a.vld, a.err, e.pc, e.pc4, e.ia, e.src, e.vld, e.err);
        end
      end
    end
  end
  initial begin
    fi.stall = 0; fi.advance = 0; fi.exc_req = 0; fi.npc_sel = 0;
    fi.br_off = 0; fi.j_target = 0; fi.jr_addr = 0;
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) insn(0, 0, 0, 0, 0);
    insn(1, 16'hFFFC, 0, 0, 0);
    insn(3, 0, 0, 32'h0040_0010, 0);
    insn(1, 16'h0003, 0, 0, 0);
    insn(3, 0, 0, 32'h0040_0010, 0);
    insn(2, 0, 26'h0100008, 0, 0);
    insn(3, 0, 0, 32'h0040_0010, 0);
    insn(3, 0, 0, 32'h0040_0100, 0);
    insn(2, 0, 26'h0100008, 0, 1);
    repeat (3) cyc(0, 0, 0, 1, 3, 0, 0, 32'h0000_1000);
    repeat (3) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    insn(3, 0, 0, 32'h0040_0102, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    insn(3, 0, 0, 32'hFFFF_FFFC, 0);
    insn(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] jr;
      jr = $urandom;
      if ($urandom_range(1) == 1) jr[1:0] = 2'b00;
      cyc($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(9) < 6,
          $urandom_range(6) == 0, 2'($urandom_range(3)), 16'($urandom), 26'($urandom), jr);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    live = 0;
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d outstanding expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
